// File: rtl/reg_wb_buffer_pkg.sv
// reg_wb_buffer_pkg: shared register-file widths, reset/write-enable polarity and queue entry type
package reg_wb_buffer_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic RESET = 1'b1;
  localparam logic EN_W = 1'b1;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/reg_wb_fifo.sv
// reg_wb_fifo: dual-push/dual-pop circular buffer; push_n/push_a/push_b in order, pop_n from head, head_0/head_1/count_o out, srch_addr_i -> youngest-match srch_hit_o/srch_data_o
module reg_wb_fifo
  import reg_wb_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        push_n_i,
  input  logic [ENT_W-1:0]  push_a_i,
  input  logic [ENT_W-1:0]  push_b_i,
  input  logic [1:0]        pop_n_i,
  output logic [ENT_W-1:0]  head_0_o,
  output logic [ENT_W-1:0]  head_1_o,
  output logic [PW:0]       count_o,
  input  logic [ADDR_W-1:0] srch_addr_i,
  output logic              srch_hit_o,
  output logic [DATA_W-1:0] srch_data_o
);
  wb_entry_t mem_q [DEPTH];
  wb_entry_t mem_d [DEPTH];
  logic [PW-1:0] rp_q, rp_d, wp_q, wp_d, idx;
  logic [PW:0] count_q, count_d;
  assign head_0_o = mem_q[rp_q];
  assign head_1_o = mem_q[rp_q + PW'(1)];
  assign count_o = count_q;
  always_comb begin
    mem_d = mem_q;
    if (push_n_i != 2'd0) mem_d[wp_q] = wb_entry_t'(push_a_i);
    if (push_n_i == 2'd2) mem_d[wp_q + PW'(1)] = wb_entry_t'(push_b_i);
    wp_d = wp_q + PW'(push_n_i);
    rp_d = rp_q + PW'(pop_n_i);
    count_d = count_q + (PW+1)'(push_n_i) - (PW+1)'(pop_n_i);
  end
  always_comb begin
    srch_hit_o = 1'b0;
    srch_data_o = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rp_q + PW'(i);
      if ((PW+1)'(i) < count_q && mem_q[idx].addr == srch_addr_i) begin
        srch_hit_o = 1'b1;
        srch_data_o = mem_q[idx].data;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i == RESET) begin
      mem_q <= '{default: '0};
      rp_q <= '0;
      wp_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      rp_q <= rp_d;
      wp_q <= wp_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/reg_wb_buffer.sv
// reg_wb_buffer: in-order writeback queue feeding the dual-write register file; res_* lanes in, res_ready_o, rd_busy_i gates drain, en_w_reg_o/w_reg_* registered writes, fwd_* lookup, count_o, wb_urgent_o
module reg_wb_buffer
  import reg_wb_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int STARVE_LIMIT = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int SW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              res_valid_1_i,
  input  logic [ADDR_W-1:0] res_addr_1_i,
  input  logic [DATA_W-1:0] res_data_1_i,
  input  logic              res_valid_2_i,
  input  logic [ADDR_W-1:0] res_addr_2_i,
  input  logic [DATA_W-1:0] res_data_2_i,
  output logic              res_ready_o,
  input  logic              rd_busy_i,
  output logic              en_w_reg_o,
  output logic [ADDR_W-1:0] w_reg_addr_1_o,
  output logic [DATA_W-1:0] w_reg_data_1_o,
  output logic [ADDR_W-1:0] w_reg_addr_2_o,
  output logic [DATA_W-1:0] w_reg_data_2_o,
  input  logic [ADDR_W-1:0] fwd_addr_i,
  output logic              fwd_hit_o,
  output logic [DATA_W-1:0] fwd_data_o,
  output logic [PW:0]       count_o,
  output logic              wb_urgent_o
);
  wb_entry_t e1, e2, push_a, head_0, head_1;
  logic [1:0] nv, push_n, pop_n;
  logic [PW:0] free;
  logic issue, fifo_hit, p1_hit, p2_hit;
  logic [DATA_W-1:0] fifo_data;
  logic en_q, en_d, urgent_q, urgent_d;
  wb_entry_t p1_q, p1_d, p2_q, p2_d;
  logic [SW-1:0] starve_q, starve_d;
  reg_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i,
    .rst_i,
    .push_n_i(push_n),
    .push_a_i(push_a),
    .push_b_i(e2),
    .pop_n_i(pop_n),
    .head_0_o(head_0),
    .head_1_o(head_1),
    .count_o,
    .srch_addr_i(fwd_addr_i),
    .srch_hit_o(fifo_hit),
    .srch_data_o(fifo_data)
  );
  always_comb begin
    e1 = {res_addr_1_i, res_data_1_i};
    e2 = {res_addr_2_i, res_data_2_i};
    nv = {1'b0, res_valid_1_i} + {1'b0, res_valid_2_i};
    free = (PW+1)'(DEPTH) - count_o;
    res_ready_o = free >= (PW+1)'(nv);
    push_n = res_ready_o ? nv : 2'd0;
    push_a = res_valid_1_i ? e1 : e2;
    issue = !rd_busy_i && count_o != '0;
    pop_n = !issue ? 2'd0 : count_o >= (PW+1)'(2) ? 2'd2 : 2'd1;
    en_d = issue ? EN_W : ~EN_W;
    p1_d = issue ? head_0 : p1_q;
    p2_d = !issue ? p2_q : pop_n == 2'd2 ? head_1 : head_0;
    starve_d = (issue || count_o == '0) ? '0 : starve_q == SW'(STARVE_LIMIT) ? starve_q : starve_q + SW'(1);
    urgent_d = starve_d >= SW'(STARVE_LIMIT);
    p2_hit = en_q && p2_q.addr == fwd_addr_i;
    p1_hit = en_q && p1_q.addr == fwd_addr_i;
    fwd_hit_o = fifo_hit || p2_hit || p1_hit;
    fwd_data_o = fifo_hit ? fifo_data : p2_hit ? p2_q.data : p1_hit ? p1_q.data : '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i == RESET) begin
      en_q <= 1'b0;
      p1_q <= '0;
      p2_q <= '0;
      starve_q <= '0;
      urgent_q <= 1'b0;
    end else begin
      en_q <= en_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
      starve_q <= starve_d;
      urgent_q <= urgent_d;
    end
  end
  assign en_w_reg_o = en_q;
  assign w_reg_addr_1_o = p1_q.addr;
  assign w_reg_data_1_o = p1_q.data;
  assign w_reg_addr_2_o = p2_q.addr;
  assign w_reg_data_2_o = p2_q.data;
  assign wb_urgent_o = urgent_q;
endmodule

// File: doc/reg_wb_buffer.md
Name: reg_wb_buffer

Overview:
- Writeback buffer directly upstream of the 8-bit x 32 register file.
- Accepts up to two results per cycle from the execute stage and queues them in order.
- Drains up to two entries per cycle onto the register file's dual write ports, only in cycles when operand fetch is not reading.
- Provides a forwarding lookup so decode can read results that are queued but not yet written.

Parameters:
DEPTH, 8, queue entries; power of 2, minimum 4
STARVE_LIMIT, 4, consecutive blocked-drain cycles before wb_urgent_o asserts
ADDR_W, 5, register address width (from shared defs)
DATA_W, 8, register data width (from shared defs)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous, active-high reset
res_valid_1_i  in  1  lane 1 result valid (older of the pair)
res_addr_1_i  in  ADDR_W  lane 1 destination register
res_data_1_i  in  DATA_W  lane 1 data
res_valid_2_i  in  1  lane 2 result valid (younger)
res_addr_2_i  in  ADDR_W  lane 2 destination register
res_data_2_i  in  DATA_W  lane 2 data
res_ready_o  in/out: out  1  both valid lanes accepted this cycle
rd_busy_i  in  1  operand fetch presents read addresses next cycle
en_w_reg_o  out  1  register-file write enable, registered
w_reg_addr_1_o  out  ADDR_W  write port 1 address, registered
w_reg_data_1_o  out  DATA_W  write port 1 data, registered
w_reg_addr_2_o  out  ADDR_W  write port 2 address, registered
w_reg_data_2_o  out  DATA_W  write port 2 data, registered
fwd_addr_i  in  ADDR_W  forwarding lookup address
fwd_hit_o  out  1  lookup matched a pending write (combinational)
fwd_data_o  out  DATA_W  youngest matching data, 0 when no hit
count_o  out  log2(DEPTH)+1  occupied entries
wb_urgent_o  out  1  request decode to yield one read slot

Behaviour:
- Reset: rst_i=1 at the clock edge clears the queue, pointers, count_o, starve counter, and all registered outputs to 0. This discards entries mid-operation. en_w_reg_o=0.
- Accept:
  - nv = res_valid_1_i + res_valid_2_i.
  - res_ready_o = (DEPTH - count) >= nv, based on current count only. A same-cycle pop gives no credit.
  - All-or-nothing acceptance.
  - Push order: lane 1 then lane 2. A lone lane-2 result occupies a single slot.
- Issue:
  - Condition: rd_busy_i=0 and count>=1 at an edge.
  - Pop min(count,2) entries into the output registers. en_w_reg_o=1 for the following cycle.
  - The older entry goes to port 1, the newer to port 2.
  - Single entry: both ports carry the same addr/data, so no spurious write occurs.
  - Two entries with the same address: the newer is on port 2, and port 2 wins in the register file.
- No issue (rd_busy_i=1 or empty): en_w_reg_o=0. Address and data outputs hold their previous values.
- Latency: a result accepted at edge N can issue at edge N+1 at the earliest. The register file is updated at edge N+2.
- Push and pop in the same cycle are allowed; count updates by pushes minus pops.
- Pointers wrap modulo DEPTH. Full: res_ready_o=0 whenever nv>0. Empty: no issue.
- Forwarding:
  - The lookup covers all valid queue entries plus the output registers while en_w_reg_o=1.
  - Priority is youngest first: queue tail, then toward head, then output port 2, then port 1.
- Starvation:
  - The counter increments each cycle in which count>=1 and rd_busy_i=1.
  - It clears on any issue, or when the queue is empty.
  - wb_urgent_o=1 while counter >= STARVE_LIMIT. It is registered.

Decomposition:
- Shared defs: ADDR_W, DATA_W, `RESET (1), `EN_W (1).
- Sub-module reg_wb_fifo: dual-push/dual-pop circular buffer with a youngest-first address search port.
- Top level: accept logic, issue registers, starve counter.

Test Plan:
- Reset, then lane1=(3,0x5A) pushed alone with rd_busy_i=0. Expect: next cycle en_w_reg_o=1 with both ports (3,0x5A), then count_o=0.
- Push (7,0x11),(7,0x22) in one cycle and issue. Expect: port1=(7,0x11), port2=(7,0x22); fwd_addr_i=7 gives 0x22 before and during issue.
- Hold rd_busy_i=1 and push 2 per cycle. Expect: count_o reaches 8 after 4 cycles, res_ready_o=0 next, wb_urgent_o=1 after 4 blocked cycles.
- From full, drop rd_busy_i. Expect: 2 pops per cycle in FIFO order, count 8→6→4→2→0, wb_urgent_o clears after the first issue.
- count=7 with both lanes valid. Expect: res_ready_o=0. Only lane 1 valid: accepted, count=8.
- Assert rst_i with 5 entries queued. Expect: next cycle count_o=0, en_w_reg_o=0, fwd_hit_o=0.
